ram2fifo_ctrl: RTL and testbench

//  Sequencer for the ram2fifo datapath. On a start pulse it reads a block of
//  len words from a synchronous RAM (1-cycle read latency) and pushes each word

---
 rtl/ram2fifo_ctrl.sv | 115 +++++++++++
 tb/tb_ram2fifo_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram2fifo_ctrl.sv
// Block-read sequencer: streams len words from a 1-cycle-latency RAM into a FIFO, stalling on prog-full.
// Optional XOR checksum output when RAM2FIFO_CHKSUM_EN is defined.
module ram2fifo_ctrl #(
    parameter int AW   = 12,
    parameter int DW   = 8,
    parameter int LENW = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [LENW-1:0] len,
    output logic            busy,
    output logic            done,
    output logic            ram_en,
    output logic [AW-1:0]   ram_addr,
    input  logic [DW-1:0]   ram_dout,
    input  logic            fifo_pfull,
    output logic            fifo_wr_en,
    output logic [DW-1:0]   fifo_din
`ifdef RAM2FIFO_CHKSUM_EN
    ,
    output logic [DW-1:0]   chk
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [LENW-1:0] remaining, remaining_nxt;
    logic [AW-1:0]   addr_nxt;
    logic            ram_en_nxt;

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        addr_nxt      = ram_addr;
        ram_en_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_nxt      = base_addr;
                    remaining_nxt = len;
                    if (len == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt  = READ;
                        ram_en_nxt = !fifo_pfull;
                    end
                end
            end
            READ: begin
                // ram_en high during a cycle means that address is issued at the next edge
                if (ram_en) begin
                    addr_nxt      = ram_addr + 1'b1;
                    remaining_nxt = remaining - 1'b1;
                end
                if (ram_en && (remaining == LENW'(1))) begin
                    state_nxt = DRAIN;
                end else begin
                    ram_en_nxt = !fifo_pfull;
                end
            end
            DRAIN: begin
                if (fifo_wr_en) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            remaining  <= '0;
            ram_addr   <= '0;
            ram_en     <= 1'b0;
            fifo_wr_en <= 1'b0;
        end else begin
            state      <= state_nxt;
            remaining  <= remaining_nxt;
            ram_addr   <= addr_nxt;
            ram_en     <= ram_en_nxt;
            fifo_wr_en <= ram_en;
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign fifo_din = ram_dout;

`ifdef RAM2FIFO_CHKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk <= '0;
        end else if ((state == IDLE) && start) begin
            chk <= '0;
        end else if (fifo_wr_en) begin
            chk <= chk ^ fifo_din;
        end
    end
`endif

endmodule

// File: tb/tb_ram2fifo_ctrl.sv
// Directed bench for ram2fifo_ctrl with a behavioural 1-cycle RAM and a FIFO write logger.
// Checksum checks are compiled in when RAM2FIFO_CHKSUM_EN is defined.
module tb_ram2fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic [11:0] len;
    logic        busy;
    logic        done;
    logic        ram_en;
    logic [11:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        fifo_pfull;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
`ifdef RAM2FIFO_CHKSUM_EN
    logic [7:0]  chk;
`endif

    int checks   = 0;
    int failures = 0;
    int wr_count = 0;
    int w0;
    logic [7:0] mem    [0:4095];
    logic [7:0] wr_log [0:63];
    logic [11:0] exp_a [0:3];

    always #5 clk = ~clk;

    ram2fifo_ctrl #(.AW(12), .DW(8), .LENW(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .ram_en     (ram_en),
        .ram_addr   (ram_addr),
        .ram_dout   (ram_dout),
        .fifo_pfull (fifo_pfull),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din)
`ifdef RAM2FIFO_CHKSUM_EN
        ,
        .chk        (chk)
`endif
    );

    always @(posedge clk) begin
        if (ram_en) ram_dout <= mem[ram_addr];
    end

    always @(posedge clk) begin
        if (fifo_wr_en) begin
            wr_log[wr_count % 64] <= fifo_din;
            wr_count <= wr_count + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = i[7:0];
        mem[12'h100] = 8'h11;
        mem[12'h101] = 8'h22;
        mem[12'h102] = 8'h44;

        rst = 1'b0; start = 1'b0; base_addr = '0; len = '0; fifo_pfull = 1'b0;
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_addr", ram_addr, 0);
`ifdef RAM2FIFO_CHKSUM_EN
        check("rst_chk", chk, 0);
`endif
        rst = 1'b1;
        step();

        // 1: base 0x010, len 4, no backpressure
        base_addr = 12'h010; len = 12'd4; start = 1'b1;
        step();
        start = 1'b0;
        w0 = wr_count;
        check("t1_busy", busy, 1);
        check("t1_en0", ram_en, 1);
        check("t1_addr0", ram_addr, 32'h010);
        check("t1_wr0", fifo_wr_en, 0);
        for (int k = 1; k < 4; k++) begin
            step();
            check("t1_en", ram_en, 1);
            check("t1_addr", ram_addr, 32'h010 + k);
            check("t1_wr", fifo_wr_en, 1);
            check("t1_din", fifo_din, 32'h10 + k - 1);
        end
        step();
        check("t1_drain_en", ram_en, 0);
        check("t1_drain_wr", fifo_wr_en, 1);
        check("t1_drain_din", fifo_din, 32'h13);
        check("t1_drain_done", done, 0);
        step();
        check("t1_done", done, 1);
        check("t1_done_busy", busy, 1);
        check("t1_done_wr", fifo_wr_en, 0);
        step();
        check("t1_idle_done", done, 0);
        check("t1_idle_busy", busy, 0);
        check("t1_wr_total", wr_count - w0, 4);

        // 2: zero-length transfer
        base_addr = 12'h020; len = 12'd0; start = 1'b1;
        step();
        start = 1'b0;
        w0 = wr_count;
        check("t2_done", done, 1);
        check("t2_busy", busy, 1);
        check("t2_en", ram_en, 0);
        check("t2_wr", fifo_wr_en, 0);
        step();
        check("t2_done_end", done, 0);
        check("t2_busy_end", busy, 0);
        check("t2_en_end", ram_en, 0);
        step();
        check("t2_wr_total", wr_count - w0, 0);

        // 3: address wrap from 0xFFF to 0x000
        exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000; exp_a[3] = 12'h001;
        base_addr = 12'hFFE; len = 12'd4; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t3_en", ram_en, 1);
            check("t3_addr", ram_addr, exp_a[k]);
            if (k > 0) check("t3_din", fifo_din, exp_a[k-1] & 12'h0FF);
            step();
        end
        check("t3_din_last", fifo_din, 32'h01);
        step();
        check("t3_done", done, 1);
        step();

        // 4: prog-full stall after the 3rd issue, held for 5 cycles
        base_addr = 12'h200; len = 12'd8; start = 1'b1;
        step();
        start = 1'b0;
        w0 = wr_count;
        check("t4_addr0", ram_addr, 32'h200);
        step();
        check("t4_addr1", ram_addr, 32'h201);
        step();
        check("t4_addr2", ram_addr, 32'h202);
        check("t4_en2", ram_en, 1);
        fifo_pfull = 1'b1;
        step();
        check("t4_stall_en_e3", ram_en, 0);
        check("t4_wr_e3", fifo_wr_en, 1);
        check("t4_din_e3", fifo_din, 32'h02);
        check("t4_addr_e3", ram_addr, 32'h203);
        for (int k = 4; k < 8; k++) begin
            step();
            check("t4_stall_en", ram_en, 0);
            check("t4_stall_wr", fifo_wr_en, 0);
            check("t4_stall_addr", ram_addr, 32'h203);
        end
        fifo_pfull = 1'b0;
        check("t4_wr_before_resume", wr_count - w0, 3);
        step();
        check("t4_resume_en", ram_en, 1);
        check("t4_resume_addr", ram_addr, 32'h203);
        check("t4_resume_wr", fifo_wr_en, 0);
        for (int k = 1; k < 5; k++) begin
            step();
            check("t4_en", ram_en, 1);
            check("t4_addr", ram_addr, 32'h203 + k);
            check("t4_din", fifo_din, 32'h02 + k);
        end
        step();
        check("t4_drain_en", ram_en, 0);
        check("t4_drain_din", fifo_din, 32'h07);
        step();
        check("t4_done", done, 1);
        step();
        check("t4_wr_total", wr_count - w0, 8);
        for (int i = 0; i < 8; i++) begin
            check("t4_order", wr_log[(w0 + i) % 64], i);
        end

        // 5: asynchronous reset mid-READ
        base_addr = 12'h300; len = 12'd6; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("t5_pre_addr", ram_addr, 32'h301);
        rst = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_en", ram_en, 0);
        check("t5_rst_wr", fifo_wr_en, 0);
        check("t5_rst_addr", ram_addr, 0);
        w0 = wr_count;
        step(); step();
        rst = 1'b1;
        step(); step();
        check("t5_no_wr", wr_count - w0, 0);
        check("t5_idle_busy", busy, 0);
        check("t5_idle_en", ram_en, 0);
        base_addr = 12'h340; len = 12'd2; start = 1'b1;
        step();
        start = 1'b0;
        check("t5_new_addr0", ram_addr, 32'h340);
        step();
        check("t5_new_addr1", ram_addr, 32'h341);
        check("t5_new_din0", fifo_din, 32'h40);
        step();
        check("t5_new_din1", fifo_din, 32'h41);
        step();
        check("t5_new_done", done, 1);
        step();

        // 6: start re-pulsed during READ is ignored
        base_addr = 12'h100; len = 12'd3; start = 1'b1;
        step();
        w0 = wr_count;
        base_addr = 12'h500; len = 12'd7;
        check("t6_addr0", ram_addr, 32'h100);
        step();
        start = 1'b0;
        check("t6_addr1", ram_addr, 32'h101);
        check("t6_din0", fifo_din, 32'h11);
        step();
        check("t6_addr2", ram_addr, 32'h102);
        check("t6_din1", fifo_din, 32'h22);
        step();
        check("t6_din2", fifo_din, 32'h44);
        check("t6_en_off", ram_en, 0);
        step();
        check("t6_done", done, 1);
`ifdef RAM2FIFO_CHKSUM_EN
        check("t6_chk_done", chk, 32'h77);
`endif
        step();
        check("t6_idle_busy", busy, 0);
        check("t6_idle_en", ram_en, 0);
        check("t6_wr_total", wr_count - w0, 3);
`ifdef RAM2FIFO_CHKSUM_EN
        check("t6_chk_hold", chk, 32'h77);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
